// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per
// clock on unsigned magnitudes, then a single FIX cycle applies signs and writes results.
module div_unit #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic         div_zero_o
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t r_state, w_next;

  logic           r_is_rem, r_sa, r_sb, r_dz;
  logic [N-1:0]   r_b, r_quo;
  logic [N:0]     r_rem;
  logic [CW-1:0]  r_cnt;

  logic           w_signed, w_b_zero, w_borrow;
  logic [N-1:0]   w_a_mag, w_b_mag, w_res;
  logic [N+1:0]   w_shift, w_trial;

  assign w_signed = ~op_i[0];
  assign w_b_zero = (b_i == '0);
  assign w_a_mag  = (w_signed && a_i[N-1]) ? -a_i : a_i;
  assign w_b_mag  = (w_signed && b_i[N-1]) ? -b_i : b_i;

  // Bit N+1 of the trial difference is the borrow: set when shifted rem < |b|.
  assign w_shift  = {r_rem, r_quo[N-1]};
  assign w_trial  = w_shift - {2'b00, r_b};
  assign w_borrow = w_trial[N+1];

  always_comb begin
    w_res = '0;
    if (r_dz)
      w_res = r_is_rem ? r_quo : '1;
    else if (r_is_rem)
      w_res = r_sa ? -r_rem[N-1:0] : r_rem[N-1:0];
    else
      w_res = (r_sa ^ r_sb) ? -r_quo : r_quo;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = w_b_zero ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CW'(N - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_is_rem   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dz       <= 1'b0;
      r_b        <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      done_o     <= 1'b0;
      result_o   <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: if (start_i) begin
          r_is_rem <= op_i[1];
          r_sa     <= w_signed & a_i[N-1];
          r_sb     <= w_signed & b_i[N-1];
          r_dz     <= w_b_zero;
          r_b      <= w_b_mag;
          // On divide-by-zero the raw dividend is parked in r_quo for REM.
          r_quo    <= w_b_zero ? a_i : w_a_mag;
          r_rem    <= '0;
          r_cnt    <= '0;
        end
        S_CALC: begin
          r_rem <= w_borrow ? w_shift[N:0] : w_trial[N:0];
          r_quo <= {r_quo[N-2:0], ~w_borrow};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          result_o   <= w_res;
          div_zero_o <= r_dz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: randomized and directed ops against a plain-arithmetic
// RISC-V division model, with latency, busy/done and reset-abort checks.
module tb_div_unit;
  localparam int N = 32;
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]   op = '0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, done, dz;
  logic [N-1:0] result;

  div_unit #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .div_zero_o(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [N-1:0] res; logic dz; int due; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int model_free = 0, acc_cyc = -1;

  function automatic logic [N-1:0] ref_model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic ovf;
    ovf = (x == MINV) && (y == '1);
    case (o)
      2'd0: return (y == 0) ? '1 : ovf ? MINV : N'($signed(x) / $signed(y));
      2'd1: return (y == 0) ? '1 : x / y;
      2'd2: return (y == 0) ? x : ovf ? '0 : N'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own idea of idleness.
  task automatic drive(input bit s, input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    @(negedge clk);
    start = s; op = o; a = x; b = y;
    if (s && cyc >= model_free) begin
      e.res = ref_model(o, x, y);
      e.dz  = (y == 0);
      e.due = cyc + 1 + ((y == 0) ? 1 : N + 1);
      sb.push_back(e);
      acc_cyc = cyc;
      model_free = e.due;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int guard = 0;
    while (cyc + 1 < model_free && guard < 200) begin
      drive(1'b0, 2'd0, '0, '0);
      guard++;
    end
    drive(1'b1, o, x, y);
  endtask

  function automatic logic [N-1:0] rnd_b();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return N'($urandom_range(1, 15));
      3: return MINV;
      default: return N'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", {63'd0, busy}, {63'd0, (cyc > acc_cyc) && (cyc < model_free)});
      if (done) begin
        if (busy) chk("busy_done_excl", 64'd1, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("div_zero", {63'd0, dz}, {63'd0, e.dz});
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_dz", {63'd0, dz}, 64'd0);
    rst = 1'b0;

    issue(2'd1, 100, 7);
    issue(2'd3, 100, 7);
    issue(2'd0, -7, 2);
    issue(2'd2, -7, 2);
    issue(2'd2, 7, -2);
    issue(2'd0, MINV, '1);
    issue(2'd2, MINV, '1);
    issue(2'd1, 5, 0);
    issue(2'd2, 5, 0);
    issue(2'd0, 32'h1234_5678, 0);
    issue(2'd3, MINV, 1);

    for (int i = 0; i < 40; i++)
      issue(2'($urandom_range(0, 3)), N'($urandom), rnd_b());

    // start_i held high every cycle: only starts seen in IDLE are accepted
    for (int i = 0; i < 200; i++)
      drive(1'b1, 2'($urandom_range(0, 3)), N'($urandom), rnd_b());
    drive(1'b0, 2'd0, '0, '0);

    // reset during the 10th iteration aborts the op with no done pulse
    issue(2'd1, 32'hDEAD_BEEF, 3);
    drive(1'b0, 2'd0, '0, '0);
    while (cyc < acc_cyc + 11) drive(1'b0, 2'd0, '0, '0);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_dz", {63'd0, dz}, 64'd0);
    sb.delete();
    model_free = 0;
    acc_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
    issue(2'd1, 100, 7);
    issue(2'd0, -100, 7);

    guard = 0;
    drive(1'b0, 2'd0, '0, '0);
    while ((sb.size() != 0 || cyc < model_free + 2) && guard < 300) begin
      drive(1'b0, 2'd0, '0, '0);
      guard++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
